// File: rtl/hebb_trainer_pkg.sv
// Shared constants, state encoding and preloaded letter patterns for the
// Hebbian weight writer.
package hebb_trainer_pkg;

    localparam int HEBB_N       = 25;
    localparam int HEBB_P_MAX   = 4;
    localparam int HEBB_W_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } hebb_state_e;

    // Bit i is neuron i of the 5x5 matrix.
    localparam logic [24:0] LETTER_D = 25'b0111010010100101001001111;
    localparam logic [24:0] LETTER_C = 25'b0011101001010000100011111;
    localparam logic [24:0] LETTER_J = 25'b1111000001000010000111110;
    localparam logic [24:0] LETTER_M = 25'b1000110001101011101110001;

    function automatic logic [24:0] default_letter(input int idx);
        case (idx)
            0:       return LETTER_D;
            1:       return LETTER_C;
            2:       return LETTER_J;
            default: return LETTER_M;
        endcase
    endfunction

endpackage

// File: rtl/hebb_term_sum.sv
// Combinational Hebbian weight W(k,m): +1 per stored pattern where neurons k
// and m agree, -1 where they differ; optional forced-zero diagonal.
module hebb_term_sum
    import hebb_trainer_pkg::*;
#(
    parameter int N         = HEBB_N,
    parameter int P_MAX     = HEBB_P_MAX,
    parameter int W_WIDTH   = HEBB_W_WIDTH,
    parameter int ZERO_DIAG = 0,
    parameter int IDX_W     = $clog2(N)
) (
    input  logic [P_MAX-1:0][N-1:0] pats,
    input  logic [2:0]              pat_count,
    input  logic [IDX_W-1:0]        k,
    input  logic [IDX_W-1:0]        m,
    output logic [W_WIDTH-1:0]      w
);

    always_comb begin
        w = '0;
        for (int p = 0; p < P_MAX; p++) begin
            if (p < int'(pat_count)) begin
                if (pats[p][k] == pats[p][m]) begin
                    w = w + W_WIDTH'(1);
                end else begin
                    w = w - W_WIDTH'(1);
                end
            end
        end
        if ((ZERO_DIAG != 0) && (k == m)) begin
            w = '0;
        end
    end

endmodule

// File: rtl/hebb_trainer.sv
// Hebbian weight writer: pattern store plus FSM that streams all N*N signed
// weights, one per clock, into the recall engine's weight memory.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | accepting patterns / clear; start launches a pass
// ST_WRITE | one lead-in cycle, then one weight write per clock, then done
// ST_DONE  | done pulse visible; return to idle next edge
module hebb_trainer
    import hebb_trainer_pkg::*;
#(
    parameter int N            = HEBB_N,
    parameter int P_MAX        = HEBB_P_MAX,
    parameter int W_WIDTH      = HEBB_W_WIDTH,
    parameter int ZERO_DIAG    = 0,
    parameter int LOAD_DEFAULT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       pat_data,
    input  logic               pat_valid,
    output logic               pat_ready,
    input  logic               clear,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               we,
    output logic [9:0]         waddr,
    output logic [W_WIDTH-1:0] wdata,
    output logic [2:0]         pat_count
);

    localparam int IDX_W = $clog2(N);
    localparam int N_DEF = (P_MAX < 4) ? P_MAX : 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    hebb_state_e               state_q, state_d;
    logic [IDX_W-1:0]          k_q, k_d;
    logic [IDX_W-1:0]          m_q, m_d;
    logic                      last_q, last_d;
    logic [P_MAX-1:0][N-1:0]   pat_q, pat_d;
    logic [2:0]                pat_count_q, pat_count_d;
    logic                      we_q, we_d;
    logic [9:0]                waddr_q, waddr_d;
    logic [W_WIDTH-1:0]        wdata_q, wdata_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [W_WIDTH-1:0]        w_km;
    logic                      accept;

    hebb_term_sum #(
        .N         (N),
        .P_MAX     (P_MAX),
        .W_WIDTH   (W_WIDTH),
        .ZERO_DIAG (ZERO_DIAG),
        .IDX_W     (IDX_W)
    ) u_term_sum (
        .pats      (pat_q),
        .pat_count (pat_count_q),
        .k         (k_q),
        .m         (m_q),
        .w         (w_km)
    );

    assign pat_ready = (state_q == ST_IDLE) && (int'(pat_count_q) < P_MAX);
    assign accept    = pat_valid && pat_ready;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        m_d         = m_q;
        last_d      = last_q;
        pat_d       = pat_q;
        pat_count_d = pat_count_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    pat_count_d = 3'd0;
                end else if (accept) begin
                    for (int p = 0; p < P_MAX; p++) begin
                        if (p == int'(pat_count_q)) begin
                            pat_d[p] = pat_data;
                        end
                    end
                    pat_count_d = pat_count_q + 3'd1;
                end
                if (start) begin
                    state_d = ST_WRITE;
                    k_d     = '0;
                    m_d     = '0;
                    last_d  = 1'b0;
                end
            end

            ST_WRITE: begin
                busy_d = 1'b1;
                // last_q marks that (N-1,N-1) has already been issued
                if (last_q) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = 10'(int'(k_q) * N + int'(m_q));
                    wdata_d = w_km;
                    if (m_q == LAST_IDX) begin
                        m_d = '0;
                        if (k_q == LAST_IDX) begin
                            last_d = 1'b1;
                        end else begin
                            k_d = k_q + IDX_W'(1);
                        end
                    end else begin
                        m_d = m_q + IDX_W'(1);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            m_q     <= '0;
            last_q  <= 1'b0;
            for (int p = 0; p < P_MAX; p++) begin
                pat_q[p] <= ((LOAD_DEFAULT != 0) && (p < 4)) ? N'(default_letter(p)) : '0;
            end
            pat_count_q <= (LOAD_DEFAULT != 0) ? 3'(N_DEF) : 3'd0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            m_q         <= m_d;
            last_q      <= last_d;
            pat_q       <= pat_d;
            pat_count_q <= pat_count_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign pat_count = pat_count_q;

endmodule

// File: tb/tb_hebb_trainer.sv
// Scoreboard bench for hebb_trainer: expected writes are queued at start and
// popped as the DUT strobes we; a second instance covers the zeroed diagonal.
module tb_hebb_trainer;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [24:0] pat_data;
    logic        pat_valid, clear, start;
    logic        pat_ready, busy, done, we;
    logic [9:0]  waddr;
    logic [3:0]  wdata;
    logic [2:0]  pat_count;

    logic        start_z;
    logic        pat_ready_z, busy_z, done_z, we_z;
    logic [9:0]  waddr_z;
    logic [3:0]  wdata_z;
    logic [2:0]  pat_count_z;

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    bit          chk_corner = 0;
    exp_t        exp_q[$];
    exp_t        qz[$];
    logic [24:0] m_pat[4];
    int          m_cnt;

    hebb_trainer #(.ZERO_DIAG(0), .LOAD_DEFAULT(1)) dut (
        .clk(clk), .rst(rst), .pat_data(pat_data), .pat_valid(pat_valid),
        .pat_ready(pat_ready), .clear(clear), .start(start), .busy(busy),
        .done(done), .we(we), .waddr(waddr), .wdata(wdata), .pat_count(pat_count)
    );

    hebb_trainer #(.ZERO_DIAG(1), .LOAD_DEFAULT(1)) dut_z (
        .clk(clk), .rst(rst), .pat_data(25'd0), .pat_valid(1'b0),
        .pat_ready(pat_ready_z), .clear(1'b0), .start(start_z), .busy(busy_z),
        .done(done_z), .we(we_z), .waddr(waddr_z), .wdata(wdata_z), .pat_count(pat_count_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_w(input int k, input int m, input bit zd);
        int s = 0;
        if (zd && k == m) return 0;
        for (int p = 0; p < m_cnt; p++) begin
            s += (m_pat[p][k] == m_pat[p][m]) ? 1 : -1;
        end
        return s;
    endfunction

    function automatic void load_defaults();
        m_pat[0] = 25'b0111010010100101001001111;
        m_pat[1] = 25'b0011101001010000100011111;
        m_pat[2] = 25'b1111000001000010000111110;
        m_pat[3] = 25'b1000110001101011101110001;
        m_cnt    = 4;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) done_cnt++;
        if (we) begin
            if (exp_q.size() == 0) begin
                chk("extra_write", int'(waddr), -1);
            end else begin
                e = exp_q.pop_front();
                chk("waddr", int'(waddr), e.addr);
                chk("wdata", int'($signed(wdata)), e.data);
            end
            if (chk_corner && waddr == 10'd0) chk("w_0_0", int'($signed(wdata)), 4);
            if (chk_corner && waddr == 10'd1) chk("w_0_1", int'($signed(wdata)), 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (we_z) begin
            if (qz.size() == 0) begin
                chk("z_extra_write", int'(waddr_z), -1);
            end else begin
                e = qz.pop_front();
                chk("z_waddr", int'(waddr_z), e.addr);
                chk("z_wdata", int'($signed(wdata_z)), e.data);
            end
            if (waddr_z % 26 == 0) chk("z_diag_zero", int'($signed(wdata_z)), 0);
        end
    end

    // Start a pass (optionally offering a pattern in the same cycle) and
    // follow it to the done pulse, checking latency and that every write landed.
    task automatic run_pass(input bit pv, input logic [24:0] pd, input bit poke);
        int done_at = 0;
        int cnt0;
        for (int a = 0; a < 625; a++) exp_q.push_back('{a, exp_w(a / 25, a % 25, 0)});
        cnt0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; pat_valid = pv; pat_data = pd;
        @(posedge clk); #1;
        start = 1'b0; pat_valid = 1'b0;
        for (int cyc = 1; cyc <= 700; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 1) chk("busy_first", int'(busy), 1);
            if (poke && cyc == 100) begin
                chk("ready_in_write", int'(pat_ready), 0);
                start = 1'b1; clear = 1'b1; pat_valid = 1'b1; pat_data = 25'h1;
            end
            if (poke && cyc == 101) begin
                start = 1'b0; clear = 1'b0; pat_valid = 1'b0;
            end
            if (done && done_at == 0) done_at = cyc;
            if (done_at != 0 && cyc == done_at + 1) break;
        end
        chk("done_cycle", done_at, 626);
        chk("done_pulses", done_cnt - cnt0, 1);
        chk("busy_after", int'(busy), 0);
        chk("we_after", int'(we), 0);
        chk("writes_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int found;
        int cnt0;
        rst = 1'b0; pat_data = '0; pat_valid = 1'b0; clear = 1'b0; start = 1'b0; start_z = 1'b0;
        load_defaults();
        #12;
        chk("rst_we", int'(we), 0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_wdata", int'(wdata), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(pat_count), 4);
        chk("rst_ready", int'(pat_ready), 0);
        @(negedge clk); rst = 1'b1;

        // store full: offer is refused
        @(posedge clk); #1; pat_valid = 1'b1; pat_data = 25'h15A5A5A;
        @(negedge clk);
        chk("full_ready", int'(pat_ready), 0);
        @(posedge clk); #1; pat_valid = 1'b0;
        chk("full_count", int'(pat_count), 4);

        // zero-diagonal instance with default letters
        for (int a = 0; a < 625; a++) qz.push_back('{a, exp_w(a / 25, a % 25, 1)});
        @(posedge clk); #1; start_z = 1'b1;
        @(posedge clk); #1; start_z = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge clk);
            if (done_z) begin found = 1; break; end
        end
        chk("z_done_seen", found, 1);
        chk("z_writes_left", qz.size(), 0);
        @(posedge clk); #1;

        // default letters, with start/clear/pattern poked mid-pass
        chk_corner = 1;
        run_pass(1'b0, 25'd0, 1'b1);
        chk_corner = 0;
        chk("count_after_poke", int'(pat_count), 4);

        // empty store
        @(posedge clk); #1; clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
        chk("clear_count", int'(pat_count), 0);
        chk("clear_ready", int'(pat_ready), 1);
        m_cnt = 0;
        run_pass(1'b0, 25'd0, 1'b0);
        chk("empty_count", int'(pat_count), 0);

        // single all-ones pattern accepted in the same cycle as start
        m_pat[0] = 25'h1FFFFFF; m_cnt = 1;
        run_pass(1'b1, 25'h1FFFFFF, 1'b0);
        chk("ones_count", int'(pat_count), 1);

        // reset in the middle of a pass
        @(posedge clk); #1; rst = 1'b0;
        #3; rst = 1'b1;
        load_defaults();
        chk("rst2_count", int'(pat_count), 4);
        for (int a = 0; a < 625; a++) exp_q.push_back('{a, exp_w(a / 25, a % 25, 0)});
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge clk);
            if (we && waddr == 10'd300) begin found = 1; break; end
        end
        chk("reached_300", found, 1);
        #1; rst = 1'b0; #1;
        exp_q.delete();
        chk("abort_we", int'(we), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_waddr", int'(waddr), 0);
        cnt0 = done_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (400) @(negedge clk);
        chk("abort_no_done", done_cnt - cnt0, 0);
        chk("abort_idle", int'(busy), 0);

        // fresh pass after the aborted one starts again at waddr 0
        chk_corner = 1;
        run_pass(1'b0, 25'd0, 1'b0);
        chk_corner = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
